// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses the program ROM and fills the IF/ID register.
// Handles stall, flush and redirect. A misaligned or out-of-range fetch sets a sticky fault and halts.
module instruction_fetch_stage #(
  parameter int unsigned              DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0]    RESET_PC     = 32'h0040_0000,
  parameter int unsigned              MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0]    NOP_INSTR    = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  input  logic [DATA_WIDTH-1:0] instruction_in,
  output logic [DATA_WIDTH-1:0] pc_address,
  output logic [DATA_WIDTH-1:0] if_id_instruction,
  output logic [DATA_WIDTH-1:0] if_id_pc,
  output logic [DATA_WIDTH-1:0] if_id_pc_plus4,
  output logic                  if_id_valid,
  output logic                  fetch_fault,
  output logic [DATA_WIDTH-1:0] fetch_fault_pc,
  output logic [DATA_WIDTH-1:0] fetch_count
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] PC_LAST =
    RESET_PC + DATA_WIDTH'(4 * MEMORY_DEPTH) - DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] ZERO    = '0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] id_pc_q, id_pc_d;
  logic [DATA_WIDTH-1:0] id_pc4_q, id_pc4_d;
  logic                  valid_q, valid_d;
  logic                  fault_q, fault_d;
  logic [DATA_WIDTH-1:0] fault_pc_q, fault_pc_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  pc_bad;
  logic                  target_misaligned;

  assign pc_plus4          = pc_q + PC_STEP;
  assign pc_bad            = (pc_q < RESET_PC) || (pc_q > PC_LAST) || (pc_q[1:0] != 2'b00);
  assign target_misaligned = redirect_target[1:0] != 2'b00;

  // Next-state logic: faults first, then redirect > flush > stall > normal fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q;

    if (state_q == ST_RUN) begin
      if (redirect_valid && target_misaligned) begin
        fault_d    = 1'b1;
        fault_pc_d = redirect_target;
        state_d    = ST_HALTED;
        instr_d    = NOP_INSTR;
        id_pc_d    = ZERO;
        id_pc4_d   = ZERO;
        valid_d    = 1'b0;
      end else if (pc_bad) begin
        fault_d    = 1'b1;
        fault_pc_d = pc_q;
        state_d    = ST_HALTED;
        instr_d    = NOP_INSTR;
        id_pc_d    = ZERO;
        id_pc4_d   = ZERO;
        valid_d    = 1'b0;
      end else if (redirect_valid) begin
        pc_d     = redirect_target;
        instr_d  = NOP_INSTR;
        id_pc_d  = ZERO;
        id_pc4_d = ZERO;
        valid_d  = 1'b0;
      end else if (flush) begin
        instr_d  = NOP_INSTR;
        id_pc_d  = ZERO;
        id_pc4_d = ZERO;
        valid_d  = 1'b0;
      end else if (!stall) begin
        instr_d  = instruction_in;
        id_pc_d  = pc_q;
        id_pc4_d = pc_plus4;
        valid_d  = 1'b1;
        pc_d     = pc_plus4;
        count_d  = count_q + DATA_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      id_pc_q    <= ZERO;
      id_pc4_q   <= ZERO;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= ZERO;
      count_q    <= ZERO;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  assign pc_address        = pc_q;
  assign if_id_instruction = instr_q;
  assign if_id_pc          = id_pc_q;
  assign if_id_pc_plus4    = id_pc4_q;
  assign if_id_valid       = valid_q;
  assign fetch_fault       = fault_q;
  assign fetch_fault_pc    = fault_pc_q;
  assign fetch_count       = count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a small combinational ROM model.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, redirect_valid;
  logic [31:0] redirect_target, instruction_in;
  logic [31:0] pc_address, if_id_instruction, if_id_pc, if_id_pc_plus4;
  logic        if_id_valid, fetch_fault;
  logic [31:0] fetch_fault_pc, fetch_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [31:0] rom [32];
  logic [31:0] word_off;

  always #5 clk = ~clk;

  instruction_fetch_stage dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .flush             (flush),
    .redirect_valid    (redirect_valid),
    .redirect_target   (redirect_target),
    .instruction_in    (instruction_in),
    .pc_address        (pc_address),
    .if_id_instruction (if_id_instruction),
    .if_id_pc          (if_id_pc),
    .if_id_pc_plus4    (if_id_pc_plus4),
    .if_id_valid       (if_id_valid),
    .fetch_fault       (fetch_fault),
    .fetch_fault_pc    (fetch_fault_pc),
    .fetch_count       (fetch_count)
  );

  // ROM: word0/1 real encodings, the rest tagged A5A5_00nn with nn the word index.
  always_comb begin
    word_off       = pc_address - 32'h0040_0000;
    instruction_in = 32'h0;
    if (word_off < 32'd128 && word_off[1:0] == 2'b00)
      instruction_in = rom[word_off[6:2]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rom[0] = 32'h0050_0093;
    rom[1] = 32'h0010_0113;
    for (int i = 2; i < 32; i++) rom[i] = {16'hA5A5, 16'(i)};

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    step();
    reset = 1'b0;
    check("rst_pc",    pc_address,        32'h0040_0000);
    check("rst_instr", if_id_instruction, 32'h0000_0013);
    check("rst_idpc",  if_id_pc,          32'h0);
    check("rst_pc4",   if_id_pc_plus4,    32'h0);
    check("rst_valid", 32'(if_id_valid),  32'd0);
    check("rst_fault", 32'(fetch_fault),  32'd0);
    check("rst_fpc",   fetch_fault_pc,    32'h0);
    check("rst_count", fetch_count,       32'd0);

    // Two sequential fetches
    step();
    check("c1_instr", if_id_instruction, 32'h0050_0093);
    check("c1_idpc",  if_id_pc,          32'h0040_0000);
    check("c1_pc4",   if_id_pc_plus4,    32'h0040_0004);
    check("c1_valid", 32'(if_id_valid),  32'd1);
    check("c1_pc",    pc_address,        32'h0040_0004);
    step();
    check("c2_instr", if_id_instruction, 32'h0010_0113);
    check("c2_idpc",  if_id_pc,          32'h0040_0004);
    check("c2_count", fetch_count,       32'd2);
    check("c2_pc",    pc_address,        32'h0040_0008);

    // Stall for three cycles at 00400008
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc",    pc_address,        32'h0040_0008);
      check("stall_idpc",  if_id_pc,          32'h0040_0004);
      check("stall_instr", if_id_instruction, 32'h0010_0113);
      check("stall_count", fetch_count,       32'd2);
    end
    stall = 1'b0;
    step();
    check("unstall_idpc",  if_id_pc,          32'h0040_0008);
    check("unstall_instr", if_id_instruction, 32'hA5A5_0002);
    check("unstall_count", fetch_count,       32'd3);
    check("unstall_pc",    pc_address,        32'h0040_000C);

    // Flush at 0040000C: bubble, same address refetched
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", 32'(if_id_valid),  32'd0);
    check("flush_instr", if_id_instruction, 32'h0000_0013);
    check("flush_idpc",  if_id_pc,          32'h0);
    check("flush_pc",    pc_address,        32'h0040_000C);
    check("flush_count", fetch_count,       32'd3);
    step();
    check("refetch_idpc",  if_id_pc,          32'h0040_000C);
    check("refetch_valid", 32'(if_id_valid),  32'd1);
    check("refetch_instr", if_id_instruction, 32'hA5A5_0003);
    check("refetch_count", fetch_count,       32'd4);

    // Redirect overrides stall
    redirect_valid = 1'b1; redirect_target = 32'h0040_0010; stall = 1'b1;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    check("redir_pc",    pc_address,        32'h0040_0010);
    check("redir_valid", 32'(if_id_valid),  32'd0);
    check("redir_instr", if_id_instruction, 32'h0000_0013);
    step();
    check("redir_idpc",  if_id_pc,          32'h0040_0010);
    check("redir_count", fetch_count,       32'd5);

    // Redirect (with flush also high) jumps forward to word 16
    redirect_valid = 1'b1; redirect_target = 32'h0040_0040; flush = 1'b1;
    step();
    redirect_valid = 1'b0; flush = 1'b0;
    check("jump_pc",    pc_address,       32'h0040_0040);
    check("jump_valid", 32'(if_id_valid), 32'd0);
    step();
    check("jump_instr", if_id_instruction, 32'hA5A5_0010);
    check("jump_pc4",   if_id_pc_plus4,    32'h0040_0044);
    check("jump_count", fetch_count,       32'd6);

    // Misaligned redirect target faults and halts
    redirect_valid = 1'b1; redirect_target = 32'h0040_0006;
    step();
    check("mis_fault", 32'(fetch_fault),  32'd1);
    check("mis_fpc",   fetch_fault_pc,    32'h0040_0006);
    check("mis_pc",    pc_address,        32'h0040_0044);
    check("mis_valid", 32'(if_id_valid),  32'd0);
    check("mis_instr", if_id_instruction, 32'h0000_0013);
    redirect_target = 32'h0040_0000;
    step();
    redirect_valid = 1'b0;
    check("halt_pc",    pc_address,       32'h0040_0044);
    check("halt_fpc",   fetch_fault_pc,   32'h0040_0006);
    check("halt_fault", 32'(fetch_fault), 32'd1);
    check("halt_count", fetch_count,      32'd6);

    // Reset clears the fault
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst2_fault", 32'(fetch_fault), 32'd0);
    check("rst2_pc",    pc_address,       32'h0040_0000);
    check("rst2_count", fetch_count,      32'd0);

    // Aligned redirect below the ROM base faults on the next cycle
    redirect_valid = 1'b1; redirect_target = 32'h003F_FFFC;
    step();
    redirect_valid = 1'b0;
    check("low_pc",    pc_address,       32'h003F_FFFC);
    check("low_fault", 32'(fetch_fault), 32'd0);
    step();
    check("low_fault2", 32'(fetch_fault), 32'd1);
    check("low_fpc",    fetch_fault_pc,   32'h003F_FFFC);

    // Run sequentially through all 32 words, then fault at 00400080
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) step();
    check("end_count", fetch_count,       32'd32);
    check("end_idpc",  if_id_pc,          32'h0040_007C);
    check("end_instr", if_id_instruction, 32'hA5A5_001F);
    check("end_pc",    pc_address,        32'h0040_0080);
    check("end_fault", 32'(fetch_fault),  32'd0);
    step();
    check("over_fault", 32'(fetch_fault), 32'd1);
    check("over_fpc",   fetch_fault_pc,   32'h0040_0080);
    check("over_count", fetch_count,      32'd32);
    check("over_valid", 32'(if_id_valid), 32'd0);
    stall = 1'b0;
    step();
    check("over_hold_pc",    pc_address,  32'h0040_0080);
    check("over_hold_count", fetch_count, 32'd32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
Fetch stage directly upstream of the program memory ROM, which it feeds, and upstream of decode, which it feeds. Owns the program counter, drives the ROM byte address, and captures the combinational ROM instruction into the IF/ID pipeline register. Handles stall, flush, branch/jump redirect, and fetch-fault detection (misaligned or out-of-range PC) with a sticky halt.

Parameters:
DATA_WIDTH, 32, width of PC, address and instruction
RESET_PC, 32'h0040_0000, first fetch address and base of program memory
MEMORY_DEPTH, 32, ROM depth in words; legal PC range is RESET_PC .. RESET_PC+4*MEMORY_DEPTH-4
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
stall  in  1  hold PC and IF/ID
flush  in  1  replace the instruction being captured with a bubble
redirect_valid  in  1  load PC from redirect_target
redirect_target  in  DATA_WIDTH  branch/jump target byte address
instruction_in  in  DATA_WIDTH  instruction returned combinationally by the ROM for pc_address
pc_address  out  DATA_WIDTH  current PC, driven straight from the PC register to the ROM Address input
if_id_instruction  out  DATA_WIDTH  registered instruction
if_id_pc  out  DATA_WIDTH  PC of if_id_instruction
if_id_pc_plus4  out  DATA_WIDTH  if_id_pc + 4
if_id_valid  out  1  IF/ID holds a real instruction
fetch_fault  out  1  sticky fault flag
fetch_fault_pc  out  DATA_WIDTH  offending address
fetch_count  out  DATA_WIDTH  number of valid instructions captured

Behaviour:
- Reset (synchronous, has priority over everything):
  - PC=RESET_PC, if_id_instruction=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=0, if_id_valid=0.
  - fetch_fault=0, fetch_fault_pc=0, fetch_count=0, state=RUN.
- FSM: RUN, HALTED. RUN->HALTED on any fault. HALTED->RUN only through reset.
- In RUN, the highest-priority rule that applies is taken each cycle:
  1. redirect_valid=1 with an aligned target (bits[1:0]=00): PC<=redirect_target; IF/ID<=bubble (NOP_INSTR, valid=0, pc fields 0). Overrides stall and flush. A misaligned target is a fault (see below).
  2. flush=1 (no redirect): IF/ID<=bubble; PC holds, so the same address is refetched next cycle. Overrides stall.
  3. stall=1: PC, IF/ID and fetch_count hold.
  4. Normal: IF/ID<={instruction_in, PC, PC+4, valid=1}; PC<=PC+4; fetch_count<=fetch_count+1.
- Latency: the instruction at pc_address appears on if_id_instruction one clock later. Throughput is 1 per cycle.
- Fault detection:
  - Checked in RUN before rules 1-4; highest-priority fault wins.
  - Misaligned redirect target: fetch_fault_pc<=redirect_target.
  - Otherwise, current PC with PC<RESET_PC, PC>RESET_PC+4*MEMORY_DEPTH-4, or PC[1:0]!=0: fetch_fault_pc<=PC.
  - On any fault: fetch_fault<=1, IF/ID<=bubble, PC holds, state<=HALTED.
- HALTED:
  - PC holds; IF/ID stays bubble; fetch_count holds.
  - stall, flush and redirect_valid are ignored.
  - fetch_fault stays 1 and fetch_fault_pc holds until reset.
- Arithmetic:
  - PC+4 is modulo 2^DATA_WIDTH; a wrap is caught by the range check.
  - fetch_count wraps modulo 2^DATA_WIDTH with no flag.
- pc_address is always equal to the PC register and has no combinational path from the inputs.

Test Plan:
- Reset, ROM word0=32'h00500093, word1=32'h00100113, no stall: cycle1 if_id_instruction=00500093, if_id_pc=00400000, if_id_pc_plus4=00400004, valid=1; cycle2 pc=00400004 instr=00100113; fetch_count=2.
- Stall held 3 cycles while PC=00400008: pc_address and IF/ID hold for 3 cycles, fetch_count unchanged; on release, capture resumes at 00400008.
- Redirect and stall both high with target 00400010: next cycle pc_address=00400010, if_id_valid=0, if_id_instruction=00000013; following cycle if_id_pc=00400010.
- Flush alone at PC=0040000C: IF/ID bubble, pc_address stays 0040000C, next cycle if_id_pc=0040000C valid=1.
- Redirect to 00400006: fetch_fault=1, fetch_fault_pc=00400006, PC unchanged, IF/ID bubble; a later redirect to 00400000 is ignored; reset clears the fault and restarts at 00400000.
- Sequential fetch past 0040007C (MEMORY_DEPTH=32): PC reaches 00400080, fault with fetch_fault_pc=00400080, fetch_count=32, HALTED.
